alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle controller in front of the combinational ALU. Accepts one opcode/operand request
//  (valid/ready), decodes the 5-bit CPU opcode to the ALU's one-hot strobes, holds them for the
//  op's latency, captures Chigh/Clow, returns the result (valid/ready). One op in flight.
// PARAMETERS
//  DATA_W      32  operand/result width
//  OP_W        5   opcode width
//  MUL_CYCLES  2   EXEC cycles for MUL (>=1)
//  DIV_CYCLES  32  EXEC cycles for DIV (>=1)
// PORTS
//  clock      in   1       single clock, rising edge
//  clear      in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       high only in IDLE
//  req_op     in   OP_W    opcode
//  req_a      in   DATA_W  operand A
//  req_b      in   DATA_W  operand B
//  alu_A      out  DATA_W  registered operand A to ALU
//  alu_B      out  DATA_W  registered operand B to ALU
//  alu_ctl    out  14      one-hot strobes: [0]ADD [1]SUB [2]MUL [3]DIV [4]AND [5]OR [6]SHR
//                          [7]SHRA [8]SHL [9]ROR [10]ROL [11]NEG [12]NOT [13]IncPC
//  alu_chigh  in   DATA_W  ALU high result
//  alu_clow   in   DATA_W  ALU low result
//  rsp_valid  out  1       result present
//  rsp_ready  in   1       consumer accepts result
//  rsp_hi     out  DATA_W  HI result; MUL/DIV only, else 0
//  rsp_lo     out  DATA_W  LO result
//  rsp_err    out  1       illegal opcode (or div-by-zero trap, see CONFIGURATION)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset (clear=0, async): state=IDLE, cnt=0. All outputs 0 except req_ready=1.
//    Reset mid-op aborts the op. No response is produced.
//  - Opcodes: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001,
//    AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, IncPC 11111.
//    All other opcodes are illegal.
//  - FSM IDLE->EXEC->RESP->IDLE:
//    IDLE: req_ready=1. On req_valid&req_ready, capture op/a/b into alu_A/alu_B.
//      Legal op: go to EXEC with cnt=lat-1. lat=1, or MUL_CYCLES for MUL, DIV_CYCLES for DIV.
//      Illegal op: go to RESP with rsp_err=1 and rsp_hi=rsp_lo=0.
//    EXEC: alu_ctl = decoded one-hot, held constant.
//      cnt!=0: cnt-- at each edge.
//      cnt==0: capture rsp_lo=alu_clow, rsp_hi=(MUL|DIV)?alu_chigh:0, rsp_err=0, then go to RESP.
//    RESP: rsp_valid=1. rsp_* stay stable until rsp_ready; on rsp_valid&rsp_ready, go to IDLE.
//  - Outside EXEC, alu_ctl=0 and at most one bit is ever set.
//  - Latency: accept edge E0. rsp_valid rises at edge E0+lat; it is E0+1 for illegal/trapped ops.
//    Throughput: one op per lat+2 cycles when rsp_ready is held high.
//  - req_valid outside IDLE is ignored and the requester must hold it. No combinational path
//    from req_* to rsp_*.
//  - cnt width is clog2(max(MUL_CYCLES,DIV_CYCLES)). No wrap: it is reloaded only on accept.
// CONFIGURATION
//  ALU_DIV0_TRAP_EN defined:
//    DIV with req_b==0 bypasses EXEC (alu_ctl stays 0) and goes to RESP next edge with
//    rsp_err=1 and rsp_hi=rsp_lo=0.
//  ALU_DIV0_TRAP_EN undefined:
//    DIV by zero runs DIV_CYCLES like any DIV, rsp_err=0, and the result is whatever the ALU returns.
// STRUCTURE
//  Package alu_seq_pkg: opcode localparams, alu_ctl bit indices, FSM state encoding, CTL_W=14.
//  Sub-module alu_op_decoder (combinational): op -> {onehot[13:0], is_mul, is_div, legal}.
//    Latency selection stays in the sequencer.
// TESTING
//  1 ADD a=3 b=4, rsp_ready=1 -> alu_ctl=14'h0001 for exactly 1 cycle; rsp_valid at E0+1,
//    rsp_lo=7, rsp_hi=0, rsp_err=0.
//  2 MUL a=32'hFFFFFFFD (-3) b=5 -> bit2 held 2 cycles; rsp_hi=32'hFFFFFFFF, rsp_lo=32'hFFFFFFF1
//    at E0+2.
//  3 op=5'b00000 -> alu_ctl never asserted; rsp_valid at E0+1 with rsp_err=1, rsp_lo=0.
//  4 rsp_ready=0 for 3 cycles after AND a=F0 b=3C -> rsp_lo=0x30 stable, req_ready=0,
//    a 2nd req_valid is not accepted; it is accepted the cycle after the handshake.
//  5 DIV, clear=0 during EXEC cycle 10 -> all outputs 0 immediately, req_ready=1, no rsp;
//    a following ADD completes normally.
//  6 DIV b=0 -> TRAP_EN build: rsp_err=1 at E0+1, alu_ctl stays 0;
//    non-TRAP build: bit3 held 32 cycles, rsp_err=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, alu_ctl strobe indices, FSM states.
package alu_seq_pkg;

    localparam int CTL_W = 14;

    localparam int CTL_ADD   = 0;
    localparam int CTL_SUB   = 1;
    localparam int CTL_MUL   = 2;
    localparam int CTL_DIV   = 3;
    localparam int CTL_AND   = 4;
    localparam int CTL_OR    = 5;
    localparam int CTL_SHR   = 6;
    localparam int CTL_SHRA  = 7;
    localparam int CTL_SHL   = 8;
    localparam int CTL_ROR   = 9;
    localparam int CTL_ROL   = 10;
    localparam int CTL_NEG   = 11;
    localparam int CTL_NOT   = 12;
    localparam int CTL_INCPC = 13;

    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_SHR   = 5'b00101;
    localparam logic [4:0] OP_SHRA  = 5'b00110;
    localparam logic [4:0] OP_SHL   = 5'b00111;
    localparam logic [4:0] OP_ROR   = 5'b01000;
    localparam logic [4:0] OP_ROL   = 5'b01001;
    localparam logic [4:0] OP_AND   = 5'b01010;
    localparam logic [4:0] OP_OR    = 5'b01011;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [4:0] OP_NEG   = 5'b10001;
    localparam logic [4:0] OP_NOT   = 5'b10010;
    localparam logic [4:0] OP_INCPC = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake plus ALU-facing signals of the op sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic                           req_valid;
    logic                           req_ready;
    logic [OP_W-1:0]                req_op;
    logic [DATA_W-1:0]              req_a;
    logic [DATA_W-1:0]              req_b;
    logic [DATA_W-1:0]              alu_A;
    logic [DATA_W-1:0]              alu_B;
    logic [alu_seq_pkg::CTL_W-1:0]  alu_ctl;
    logic [DATA_W-1:0]              alu_chigh;
    logic [DATA_W-1:0]              alu_clow;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [DATA_W-1:0]              rsp_hi;
    logic [DATA_W-1:0]              rsp_lo;
    logic                           rsp_err;
    logic                           busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_chigh, alu_clow, rsp_ready,
        output req_ready, alu_A, alu_B, alu_ctl, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_chigh, alu_clow, rsp_ready,
        input  req_ready, alu_A, alu_B, alu_ctl, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational CPU opcode -> one-hot ALU strobe decoder with MUL/DIV flags and legality.
module alu_op_decoder
    import alu_seq_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0]  op,
    output logic [CTL_W-1:0] onehot,
    output logic             is_mul,
    output logic             is_div,
    output logic             legal
);

    always_comb begin
        onehot = '0;
        legal  = 1'b1;
        case (5'(op))
            OP_ADD:   onehot[CTL_ADD]   = 1'b1;
            OP_SUB:   onehot[CTL_SUB]   = 1'b1;
            OP_SHR:   onehot[CTL_SHR]   = 1'b1;
            OP_SHRA:  onehot[CTL_SHRA]  = 1'b1;
            OP_SHL:   onehot[CTL_SHL]   = 1'b1;
            OP_ROR:   onehot[CTL_ROR]   = 1'b1;
            OP_ROL:   onehot[CTL_ROL]   = 1'b1;
            OP_AND:   onehot[CTL_AND]   = 1'b1;
            OP_OR:    onehot[CTL_OR]    = 1'b1;
            OP_MUL:   onehot[CTL_MUL]   = 1'b1;
            OP_DIV:   onehot[CTL_DIV]   = 1'b1;
            OP_NEG:   onehot[CTL_NEG]   = 1'b1;
            OP_NOT:   onehot[CTL_NOT]   = 1'b1;
            OP_INCPC: onehot[CTL_INCPC] = 1'b1;
            default:  legal             = 1'b0;
        endcase
        is_mul = onehot[CTL_MUL];
        is_div = onehot[CTL_DIV];
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller in front of the combinational ALU: IDLE -> EXEC -> RESP.
// Optional ALU_DIV0_TRAP_EN: DIV by zero is reported as an error instead of being executed.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 5,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clock,
    input  logic               clear,
    alu_op_sequencer_if.slave  bus
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [CTL_W-1:0]   ctl_q, ctl_d;
    logic               trap_q, trap_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic               err_q, err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;

    logic [CTL_W-1:0]   dec_onehot;
    logic               dec_is_mul;
    logic               dec_is_div;
    logic               dec_legal;
    logic               div0_trap;
    logic [CNT_W-1:0]   lat_m1;

    alu_op_decoder #(
        .OP_W (OP_W)
    ) u_dec (
        .op     (bus.req_op),
        .onehot (dec_onehot),
        .is_mul (dec_is_mul),
        .is_div (dec_is_div),
        .legal  (dec_legal)
    );

    always_comb begin
`ifdef ALU_DIV0_TRAP_EN
        div0_trap = dec_is_div && (bus.req_b == '0);
`else
        div0_trap = 1'b0;
`endif
        if (dec_is_mul)      lat_m1 = CNT_W'(MUL_CYCLES - 1);
        else if (dec_is_div) lat_m1 = CNT_W'(DIV_CYCLES - 1);
        else                 lat_m1 = '0;
    end

    // Illegal and trapped ops still spend one EXEC cycle, strobes off, so their
    // response appears one edge after accept just like a single-cycle op.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        ctl_d       = ctl_q;
        trap_d      = trap_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d         = bus.req_a;
                    b_d         = bus.req_b;
                    state_d     = ST_EXEC;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (dec_legal && !div0_trap) begin
                        cnt_d  = lat_m1;
                        ctl_d  = dec_onehot;
                        trap_d = 1'b0;
                    end else begin
                        cnt_d  = '0;
                        ctl_d  = '0;
                        trap_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ctl_d       = '0;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    err_d       = trap_q;
                    if (trap_q) begin
                        hi_d = '0;
                        lo_d = '0;
                    end else begin
                        lo_d = bus.alu_clow;
                        hi_d = (ctl_q[CTL_MUL] || ctl_q[CTL_DIV]) ? bus.alu_chigh : '0;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                ctl_d       = '0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctl_q       <= '0;
            trap_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctl_q       <= ctl_d;
            trap_q      <= trap_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.alu_A     = a_q;
    assign bus.alu_B     = b_q;
    assign bus.alu_ctl   = ctl_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hi    = hi_q;
    assign bus.rsp_lo    = lo_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: transaction model plus directed scenarios.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [13:0] ctl;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } exp_t;

    logic clock;
    logic clear;
    int   n_tests;
    int   n_fail;

    alu_op_sequencer_if #(.DATA_W(32), .OP_W(5)) bus ();

    alu_op_sequencer #(
        .DATA_W     (32),
        .OP_W       (5),
        .MUL_CYCLES (2),
        .DIV_CYCLES (32)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU arithmetic: index = strobe position, returns {chigh, clow}.
    function automatic logic [63:0] alu_math(input int idx, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] garb;
        logic [4:0]  s;
        longint      p;
        garb = 32'hDEAD_BEEF;
        s    = b[4:0];
        case (idx)
            0:  return {garb, a + b};
            1:  return {garb, a - b};
            2:  begin
                    p = longint'($signed(a)) * longint'($signed(b));
                    return p;
                end
            3:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            4:  return {garb, a & b};
            5:  return {garb, a | b};
            6:  return {garb, a >> s};
            7:  return {garb, 32'($signed(a) >>> s)};
            8:  return {garb, a << s};
            9:  return {garb, (s == 0) ? a : ((a >> s) | (a << (6'd32 - 6'(s))))};
            10: return {garb, (s == 0) ? a : ((a << s) | (a >> (6'd32 - 6'(s))))};
            11: return {garb, -a};
            12: return {garb, ~a};
            13: return {garb, a + 32'd1};
            default: return 64'd0;
        endcase
    endfunction

    // Combinational ALU stand-in driven by the sequencer's strobes.
    int stub_idx;
    always_comb begin
        stub_idx = -1;
        for (int i = 0; i < 14; i++) if (bus.alu_ctl[i]) stub_idx = i;
        {bus.alu_chigh, bus.alu_clow} = alu_math(stub_idx, bus.alu_A, bus.alu_B);
    end

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          idx;
        int          lat;
        logic        ok;
        logic [63:0] r;
        ok  = 1'b1;
        lat = 1;
        idx = -1;
        case (op)
            5'b00011: idx = 0;
            5'b00100: idx = 1;
            5'b00101: idx = 6;
            5'b00110: idx = 7;
            5'b00111: idx = 8;
            5'b01000: idx = 9;
            5'b01001: idx = 10;
            5'b01010: idx = 4;
            5'b01011: idx = 5;
            5'b01111: begin idx = 2; lat = 2;  end
            5'b10000: begin idx = 3; lat = 32; end
            5'b10001: idx = 11;
            5'b10010: idx = 12;
            5'b11111: idx = 13;
            default:  ok = 1'b0;
        endcase
`ifdef ALU_DIV0_TRAP_EN
        if (op == 5'b10000 && b == 0) ok = 1'b0;
`endif
        e.a = a;
        e.b = b;
        if (!ok) begin
            e.ctl = '0; e.lat = 1; e.hi = '0; e.lo = '0; e.err = 1'b1;
        end else begin
            r     = alu_math(idx, a, b);
            e.ctl = 14'(1) << idx;
            e.lat = lat;
            e.lo  = r[31:0];
            e.hi  = (idx == 2 || idx == 3) ? r[63:32] : 32'd0;
            e.err = 1'b0;
        end
        return e;
    endfunction

    // Model state, written only by the edge monitor.
    exp_t ex;
    logic in_flight;
    int   cyc;
    int   e0;
    int   hs_cyc;
    int   acc_log[$];
    logic rdy_s;
    logic rv_s;

    initial begin
        in_flight = 1'b0;
        cyc       = 0;
        e0        = 0;
        hs_cyc    = -1;
        rdy_s     = 1'b0;
        rv_s      = 1'b0;
    end

    always @(posedge clock) begin
        if (!clear) begin
            in_flight = 1'b0;
        end else begin
            if (in_flight && rv_s && bus.rsp_ready) begin
                in_flight = 1'b0;
                hs_cyc    = cyc;
            end
            if (bus.req_valid && rdy_s) begin
                in_flight = 1'b1;
                e0        = cyc;
                ex        = model(bus.req_op, bus.req_a, bus.req_b);
                acc_log.push_back(cyc);
            end
        end
        cyc = cyc + 1;
    end

    int cmp_n;
    always @(negedge clock) begin
        rdy_s = bus.req_ready;
        rv_s  = bus.rsp_valid;
        if (!clear) begin
            chk("rst_req_ready", bus.req_ready, 1);
            chk("rst_busy",      bus.busy, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_ctl",       bus.alu_ctl, 0);
            chk("rst_rsp_lo",    bus.rsp_lo, 0);
        end else begin
            chk("ctl_onehot0", $onehot0(bus.alu_ctl), 1);
            chk("busy_vs_ready", bus.busy, !bus.req_ready);
            if (in_flight) begin
                cmp_n = cyc - e0 - 1;
                if (cmp_n < ex.lat) begin
                    chk("exec_ctl",   bus.alu_ctl, ex.ctl);
                    chk("exec_valid", bus.rsp_valid, 0);
                    chk("exec_ready", bus.req_ready, 0);
                    chk("exec_alu_A", bus.alu_A, ex.a);
                    chk("exec_alu_B", bus.alu_B, ex.b);
                end else begin
                    chk("resp_valid", bus.rsp_valid, 1);
                    chk("resp_hi",    bus.rsp_hi, ex.hi);
                    chk("resp_lo",    bus.rsp_lo, ex.lo);
                    chk("resp_err",   bus.rsp_err, ex.err);
                    chk("resp_ctl",   bus.alu_ctl, 0);
                end
            end else begin
                chk("idle_ready", bus.req_ready, 1);
                chk("idle_valid", bus.rsp_valid, 0);
                chk("idle_ctl",   bus.alu_ctl, 0);
            end
        end
    end

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting, required event never seen", name);
    endtask

    // One request; returns response fields, edges-to-valid and cycles with strobes active.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] hi, output logic [31:0] lo,
                        output logic err, output int lat, output int ctl_cyc);
        int g;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = (hold == 0);
        g = 0;
        while (!bus.req_ready && g < 100) begin @(negedge clock); g++; end
        if (g >= 100) timeout("accept");
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 0; ctl_cyc = 0; g = 0;
        while (!bus.rsp_valid && g < 100) begin
            if (bus.alu_ctl != 0) ctl_cyc++;
            @(negedge clock);
            lat++; g++;
        end
        if (g >= 100) timeout("rsp_valid");
        hi  = bus.rsp_hi;
        lo  = bus.rsp_lo;
        err = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            chk("hold_lo",    bus.rsp_lo, lo);
            chk("hold_ready", bus.req_ready, 0);
            @(negedge clock);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic drain();
        int g;
        bus.rsp_ready = 1'b1;
        g = 0;
        while (!bus.req_ready && g < 100) begin @(negedge clock); g++; end
        if (g >= 100) timeout("drain");
    endtask

    localparam int NV = 12;
    logic [4:0]  v_op[NV] = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                              5'b01011, 5'b10000, 5'b10001, 5'b10010, 5'b11111, 5'b11110};
    logic [31:0] v_a[NV]  = '{32'd10, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1, 32'h8000_0000,
                              32'h00F0, 32'd100, 32'd5, 32'h0F0F_0000, 32'h0000_0FFF, 32'd9};
    logic [31:0] v_b[NV]  = '{32'd3, 32'd4, 32'd4, 32'd31, 32'd1, 32'd1,
                              32'h000F, 32'd7, 32'd0, 32'd0, 32'd0, 32'd9};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hi, lo;
        logic        err;
        int          lat, cc, na, g;
        exp_t        m;
        n_tests = 0;
        n_fail  = 0;
        clear   = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        #2 clear = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_alu_A", bus.alu_A, 0);
        clear = 1'b1;

        // Model pinned to hand-computed values.
        m = model(5'b01111, 32'hFFFF_FFFD, 32'd5);
        chk("model_mul_hi", m.hi, 32'hFFFF_FFFF);
        chk("model_mul_lo", m.lo, 32'hFFFF_FFF1);

        // ADD 3+4
        send(5'b00011, 32'd3, 32'd4, 0, hi, lo, err, lat, cc);
        chk("add_lat", lat, 1);
        chk("add_ctl_cycles", cc, 1);
        chk("add_lo", lo, 7);
        chk("add_hi", hi, 0);
        chk("add_err", err, 0);

        // MUL -3*5
        send(5'b01111, 32'hFFFF_FFFD, 32'd5, 0, hi, lo, err, lat, cc);
        chk("mul_lat", lat, 2);
        chk("mul_ctl_cycles", cc, 2);
        chk("mul_hi", hi, 32'hFFFF_FFFF);
        chk("mul_lo", lo, 32'hFFFF_FFF1);

        // Illegal opcode 0
        send(5'b00000, 32'd1, 32'd2, 0, hi, lo, err, lat, cc);
        chk("ill_lat", lat, 1);
        chk("ill_ctl_cycles", cc, 0);
        chk("ill_err", err, 1);
        chk("ill_lo", lo, 0);

        // Remaining opcodes against the model
        for (int i = 0; i < NV; i++) begin
            m = model(v_op[i], v_a[i], v_b[i]);
            send(v_op[i], v_a[i], v_b[i], 0, hi, lo, err, lat, cc);
            chk("vec_lat", lat, m.lat);
            chk("vec_lo", lo, m.lo);
        end

        // AND with back-pressure and a second request held during RESP
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_op = 5'b01010; bus.req_a = 32'hF0; bus.req_b = 32'h3C;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        bus.req_op = 5'b00011; bus.req_a = 32'd1; bus.req_b = 32'd2;
        g = 0;
        while (!bus.rsp_valid && g < 100) begin @(negedge clock); g++; end
        if (g >= 100) timeout("and_rsp");
        for (int i = 0; i < 3; i++) begin
            chk("bp_lo", bus.rsp_lo, 32'h30);
            chk("bp_req_ready", bus.req_ready, 0);
            @(negedge clock);
        end
        bus.rsp_ready = 1'b1;
        na = acc_log.size();
        @(negedge clock);
        chk("bp_no_early_accept", acc_log.size(), na);
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("bp_accept_count", acc_log.size(), na + 1);
        chk("bp_accept_cycle", acc_log[acc_log.size() - 1], hs_cyc + 1);
        drain();

        // Throughput: MUL back-to-back with rsp_ready held
        @(negedge clock);
        na = acc_log.size();
        bus.req_valid = 1'b1; bus.req_op = 5'b01111; bus.req_a = 32'd2; bus.req_b = 32'd3;
        g = 0;
        while (acc_log.size() < na + 2 && g < 100) begin @(negedge clock); g++; end
        bus.req_valid = 1'b0;
        if (g >= 100) timeout("throughput");
        else chk("throughput_gap", acc_log[na + 1] - acc_log[na], 4);
        drain();

        // Reset during the 10th EXEC cycle of a DIV
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_op = 5'b10000; bus.req_a = 32'd100; bus.req_b = 32'd3;
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clock);
        chk("div_busy_before_rst", bus.busy, 1);
        #2 clear = 1'b0;
        #1;
        chk("arst_ctl", bus.alu_ctl, 0);
        chk("arst_alu_A", bus.alu_A, 0);
        chk("arst_req_ready", bus.req_ready, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(negedge clock);
        clear = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("arst_no_rsp", bus.rsp_valid, 0);
        end
        send(5'b00011, 32'd5, 32'd6, 0, hi, lo, err, lat, cc);
        chk("post_rst_add_lo", lo, 11);

        // DIV by zero
        send(5'b10000, 32'd77, 32'd0, 0, hi, lo, err, lat, cc);
`ifdef ALU_DIV0_TRAP_EN
        chk("div0_lat", lat, 1);
        chk("div0_ctl_cycles", cc, 0);
        chk("div0_err", err, 1);
        chk("div0_lo", lo, 0);
`else
        chk("div0_lat", lat, 32);
        chk("div0_ctl_cycles", cc, 32);
        chk("div0_err", err, 0);
        chk("div0_hi", hi, 77);
`endif

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
